// File: rtl/pe_accum_seq.sv
// Sequential accumulate controller for one systolic PE; drives an external 8-bit add/sub ALU.
// Optional operand forwarding to the east neighbour is enabled with `define PE_PASSTHRU_EN.
module pe_accum_seq #(
  parameter int DW      = 8,
  parameter int CNT_W   = 4,
  parameter int MAX_OPS = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_add_sub,
  input  logic          in_last,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic          alu_add_sub,
  output logic          alu_enable,
  input  logic [DW-1:0] alu_result,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
`ifdef PE_PASSTHRU_EN
  output logic          east_valid,
  output logic [DW-1:0] east_data,
  output logic          east_add_sub,
`endif
  output logic          res_err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

  state_t             state, state_nxt;
  logic [DW-1:0]      acc;
  logic [DW-1:0]      opnd_p0;
  logic               opc_p0;
  logic               last_p0;
  logic [CNT_W-1:0]   op_cnt;
  logic               err_r;
  logic               accept;
  logic               done_cond;

  assign accept    = in_valid && in_ready;
  assign done_cond = last_p0 || (op_cnt == MAX_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC: begin
        if (done_cond)   state_nxt = DONE;
        else if (accept) state_nxt = EXEC;
        else             state_nxt = IDLE;
      end
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state != DONE);
    alu_enable = (state == EXEC);
    res_valid  = (state == DONE);
  end

  assign alu_in1     = acc;
  assign alu_in2     = opnd_p0;
  assign alu_add_sub = opc_p0;
  assign res_data    = acc;
  assign res_err     = err_r;

  // Operand capture / accumulate stage; a run ending on MAX_OPS ignores a
  // coincident accept so no operand is loaded into a finished run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      opnd_p0 <= '0;
      opc_p0  <= 1'b0;
      last_p0 <= 1'b0;
      op_cnt  <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opnd_p0 <= in_data;
            opc_p0  <= in_add_sub;
            last_p0 <= in_last;
            op_cnt  <= CNT_W'(1);
          end
        end
        EXEC: begin
          acc <= alu_result;
          if (done_cond) begin
            err_r <= !last_p0;
          end else if (accept) begin
            opnd_p0 <= in_data;
            opc_p0  <= in_add_sub;
            last_p0 <= in_last;
            op_cnt  <= op_cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            acc    <= '0;
            op_cnt <= '0;
            err_r  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PE_PASSTHRU_EN
  logic          east_vld_p1;
  logic [DW-1:0] east_data_p1;
  logic          east_opc_p1;

  // Forwarding stage: one-cycle copy of every accepted operand, no backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      east_vld_p1  <= 1'b0;
      east_data_p1 <= '0;
      east_opc_p1  <= 1'b0;
    end else begin
      east_vld_p1 <= accept;
      if (accept) begin
        east_data_p1 <= in_data;
        east_opc_p1  <= in_add_sub;
      end
    end
  end

  assign east_valid   = east_vld_p1;
  assign east_data    = east_data_p1;
  assign east_add_sub = east_opc_p1;
`endif

endmodule

// File: tb/tb_pe_accum_seq.sv
// Scoreboard bench for pe_accum_seq with a behavioural ALU; results are compared on the result handshake.
module tb_pe_accum_seq;
  localparam int DW      = 8;
  localparam int MAX_OPS = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, in_add_sub, in_last;
  logic [DW-1:0] in_data;
  logic [DW-1:0] alu_in1, alu_in2, alu_result;
  logic          alu_add_sub, alu_enable;
  logic          res_valid, res_ready, res_err;
  logic [DW-1:0] res_data;
`ifdef PE_PASSTHRU_EN
  logic          east_valid, east_add_sub;
  logic [DW-1:0] east_data;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] m_acc = '0;
  int            m_cnt = 0;

  pe_accum_seq #(.DW(DW), .CNT_W(4), .MAX_OPS(MAX_OPS)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_add_sub(in_add_sub), .in_last(in_last),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_add_sub(alu_add_sub),
    .alu_enable(alu_enable), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef PE_PASSTHRU_EN
    .east_valid(east_valid), .east_data(east_data), .east_add_sub(east_add_sub),
`endif
    .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: modulo-2^DW add/sub, zero when disabled.
  assign alu_result = !alu_enable ? '0 :
                      alu_add_sub ? DW'(alu_in1 + alu_in2) : DW'(alu_in1 - alu_in2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_op(input logic [DW-1:0] d, input logic add, input logic last);
    m_acc = add ? DW'(m_acc + d) : DW'(m_acc - d);
    m_cnt++;
    if (last || m_cnt == MAX_OPS) begin
      exp_q.push_back({!last, m_acc});
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  // Leaves in_valid asserted so consecutive calls stream back-to-back.
  task automatic send_op(input logic [DW-1:0] d, input logic add, input logic last);
    int n;
    in_valid = 1'b1; in_data = d; in_add_sub = add; in_last = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    model_op(d, add, last);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Result monitor: pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {23'd0, res_err, res_data}, 32'hFFFF);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        chk("res_data", res_data, e[DW-1:0]);
        chk("res_err", res_err, e[DW]);
      end
    end
  end

`ifdef PE_PASSTHRU_EN
  logic          pend_acc = 1'b0;
  logic [DW-1:0] pend_data;
  logic          pend_opc;
  always @(negedge clk) begin
    if (!reset_n) begin
      pend_acc = 1'b0;
    end else begin
      chk("east_valid", east_valid, pend_acc);
      if (pend_acc) begin
        chk("east_data", east_data, pend_data);
        chk("east_add_sub", east_add_sub, pend_opc);
      end
      pend_acc  = in_valid && in_ready;
      pend_data = in_data;
      pend_opc  = in_add_sub;
    end
  end
`endif

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_add_sub = 1'b0; in_last = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_alu_enable", alu_enable, 1'b0);
    chk("rst_res_data", res_data, 8'h00);
    chk("rst_res_err", res_err, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Back-to-back add with latency probe.
    send_op(8'h10, 1'b1, 1'b0);
    send_op(8'h20, 1'b1, 1'b0);
    send_op(8'h03, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_exec_en", alu_enable, 1'b1);
    chk("lat_exec_vld", res_valid, 1'b0);
    @(negedge clk);
    chk("lat_done_vld", res_valid, 1'b1);
    chk("lat_done_data", res_data, 8'h33);
    wait_drain();
    @(negedge clk);
    chk("idle_alu_en", alu_enable, 1'b0);
    chk("idle_acc_clr", alu_in1, 8'h00);
    @(posedge clk); #1;

    // Reset in the middle of a run.
    send_op(8'h40, 1'b1, 1'b0);
    send_op(8'h02, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_alu_en", alu_enable, 1'b0);
    chk("midrst_acc", alu_in1, 8'h00);
    chk("midrst_opnd", alu_in2, 8'h00);
    chk("midrst_res_valid", res_valid, 1'b0);
    m_acc = '0; m_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    send_op(8'h05, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Subtract wrap and add overflow wrap.
    send_op(8'h01, 1'b1, 1'b0);
    send_op(8'h02, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    send_op(8'hF0, 1'b1, 1'b0);
    send_op(8'h20, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Result backpressure with a held operand.
    res_ready = 1'b0;
    send_op(8'h07, 1'b1, 1'b0);
    send_op(8'h09, 1'b1, 1'b1);
    in_valid = 1'b1; in_data = 8'hAA; in_add_sub = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("bp_res_valid", res_valid, 1'b1);
        chk("bp_res_data", res_data, 8'h10);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_alu_en", alu_enable, 1'b0);
      end
    end
    @(posedge clk); #1;
    model_op(8'hAA, 1'b1, 1'b1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_acc", alu_in1, 8'h00);
    chk("bp_release_rdy", in_ready, 1'b1);
    chk("bp_release_en", alu_enable, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    // MAX_OPS termination.
    for (int i = 0; i < MAX_OPS; i++) send_op(8'h01, 1'b1, 1'b0);
    in_valid = 1'b0;
    wait_drain();
    chk("max_err_clr", res_err, 1'b0);

    // Gapped input reaches the same sum as back-to-back.
    send_op(8'h10, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("gap_idle_en", alu_enable, 1'b0);
    @(posedge clk); #1;
    send_op(8'h20, 1'b1, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_op(8'h03, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    chk("sb_left", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
